upack_channel_sequencer: RTL and testbench

//  Sequences the unpacker's per-beat channel slots from a channel enable mask.
//  - Emits one slot per enabled channel, in ascending index order, over a valid/ready handshake.
//  - Prefixes each frame with an optional timestamp slot.
//  - Latches mask changes only at frame boundaries.
//  - Publishes the enabled-channel count, which the downstream unpacker uses for width selection.

---
 rtl/upack_channel_sequencer_pkg.sv | 11 +
 rtl/upack_channel_sequencer_if.sv | 32 +++
 rtl/count_bits.sv | 17 +
 rtl/upack_next_channel.sv | 31 +++
 rtl/upack_channel_sequencer.sv | 152 +++++++++++++++
 tb/tb_upack_channel_sequencer.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/upack_channel_sequencer_pkg.sv
// Shared definitions for the unpacker channel sequencer.
// Holds the binary FSM state encoding used by the sequencer.
package upack_channel_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/upack_channel_sequencer_if.sv
// Slot stream from the sequencer to the unpacker datapath.
// Valid/ready handshake plus per-slot framing information.
interface upack_channel_sequencer_if #(
   parameter int CW = 2
) ();

   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_channel;
   logic          out_ts;
   logic          out_first;
   logic          out_last;

   modport master (
      output out_valid,
      output out_channel,
      output out_ts,
      output out_first,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_channel,
      input  out_ts,
      input  out_first,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/count_bits.sv
// Population count of a bit vector.
// Purely combinational.
module count_bits #(
   parameter int BITS_WIDTH = 4
) (
   input  logic [BITS_WIDTH-1:0]       bits,
   output logic [$clog2(BITS_WIDTH):0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < BITS_WIDTH; i++) begin
         count = count + {{$clog2(BITS_WIDTH){1'b0}}, bits[i]};
      end
   end

endmodule

// File: rtl/upack_next_channel.sv
// Finds the next enabled channel above the current index.
// With restart set, the search starts from index 0 inclusive.
module upack_next_channel #(
   parameter  int N  = 4,
   localparam int CW = $clog2(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [CW-1:0] cur,
   input  logic          restart,
   output logic [CW-1:0] next,
   output logic          found,
   output logic          is_last
);

   // Descending scan so the lowest qualifying index wins.
   always_comb begin
      next    = '0;
      found   = 1'b0;
      is_last = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i] && (restart || i > int'(cur))) begin
            next  = CW'(i);
            found = 1'b1;
         end
         if (mask[i] && i > int'(cur)) begin
            is_last = 1'b0;
         end
      end
   end

endmodule

// File: rtl/upack_channel_sequencer.sv
// Emits one slot per enabled channel per frame, optionally led by a
// timestamp slot; the enable mask is only adopted at frame boundaries.
module upack_channel_sequencer
   import upack_channel_sequencer_pkg::*;
#(
   parameter  int NUM_OF_CHANNELS = 4,
   parameter  int TIMESTAMP_EN    = 1,
   localparam int N               = NUM_OF_CHANNELS,
   localparam int CW              = $clog2(NUM_OF_CHANNELS)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          run,
   input  logic [N-1:0]  enable,
   input  logic          cfg_update,
   output logic          cfg_pending,
   output logic [N-1:0]  active_mask,
   output logic [CW:0]   active_count,
   upack_channel_sequencer_if.master slot
);

   localparam bit TS = (TIMESTAMP_EN != 0);

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic          slot_ts;
   logic          slot_first;
   logic [CW-1:0] slot_ch;

   logic          consume;
   logic [N-1:0]  mask_src;
   logic [CW:0]   pop;
   logic          run_st;
   logic          accept;
   logic          last_slot;
   logic          frame_end;

   logic [CW-1:0] start_next;
   logic          start_found;
   logic          start_last;
   logic [CW-1:0] step_next;
   logic          step_found;
   logic          step_last;
   logic          unused;

   assign consume   = (state == LOAD) &&
                      (cfg_pending || active_mask == '0);
   assign mask_src  = consume ? enable : active_mask;
   assign run_st    = (state == RUN);
   assign accept    = run_st && slot.out_ready;
   assign last_slot = !slot_ts && step_last;
   assign frame_end = accept && last_slot;
   assign unused    = ^{start_last, step_found};

   count_bits #(
      .BITS_WIDTH (N)
   ) u_count (
      .bits  (enable),
      .count (pop)
   );

   // Frame start: lowest channel of the mask about to be in use.
   upack_next_channel #(
      .N (N)
   ) u_start (
      .mask    (mask_src),
      .cur     ('0),
      .restart (1'b1),
      .next    (start_next),
      .found   (start_found),
      .is_last (start_last)
   );

   upack_next_channel #(
      .N (N)
   ) u_step (
      .mask    (active_mask),
      .cur     (slot_ch),
      .restart (1'b0),
      .next    (step_next),
      .found   (step_found),
      .is_last (step_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (run) state_nxt = LOAD;
         end
         LOAD: begin
            state_nxt = start_found ? RUN : IDLE;
         end
         RUN: begin
            if (frame_end) begin
               if (!run)            state_nxt = IDLE;
               else if (cfg_pending) state_nxt = LOAD;
               else                  state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      slot.out_valid   = run_st;
      slot.out_ts      = run_st && slot_ts;
      slot.out_first   = run_st && slot_first;
      slot.out_last    = run_st && last_slot;
      slot.out_channel = run_st ? slot_ch : '0;
   end

   // Slot cursor; reloaded at frame start, advanced on acceptance.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         slot_ts    <= 1'b0;
         slot_first <= 1'b0;
         slot_ch    <= '0;
      end else if (state == LOAD || frame_end) begin
         slot_ts    <= TS;
         slot_first <= 1'b1;
         slot_ch    <= TS ? '0 : start_next;
      end else if (accept) begin
         slot_ts    <= 1'b0;
         slot_first <= 1'b0;
         slot_ch    <= slot_ts ? start_next : step_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_pending  <= 1'b0;
         active_mask  <= '0;
         active_count <= '0;
      end else begin
         cfg_pending <= cfg_update || (cfg_pending && !consume);
         if (consume) begin
            active_mask  <= enable;
            active_count <= pop;
         end
      end
   end

endmodule

// File: tb/tb_upack_channel_sequencer.sv
// Directed scoreboard bench for upack_channel_sequencer.
// Covers timestamp and non-timestamp instances.
module tb_upack_channel_sequencer;

   logic       clk;
   logic       resetn;
   logic       run;
   logic [3:0] enable;
   logic       cfg_update;
   logic       cfg_pending;
   logic [3:0] active_mask;
   logic [2:0] active_count;

   logic       run0;
   logic [3:0] enable0;
   logic       cfg0;
   logic       pending0;
   logic [3:0] mask0;
   logic [2:0] count0;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [4:0] q[$];
   logic [4:0] q0[$];

   upack_channel_sequencer_if #(.CW(2)) bus ();
   upack_channel_sequencer_if #(.CW(2)) bus0 ();

   upack_channel_sequencer #(
      .NUM_OF_CHANNELS (4),
      .TIMESTAMP_EN    (1)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .run          (run),
      .enable       (enable),
      .cfg_update   (cfg_update),
      .cfg_pending  (cfg_pending),
      .active_mask  (active_mask),
      .active_count (active_count),
      .slot         (bus.master)
   );

   upack_channel_sequencer #(
      .NUM_OF_CHANNELS (4),
      .TIMESTAMP_EN    (0)
   ) dut0 (
      .clk          (clk),
      .resetn       (resetn),
      .run          (run0),
      .enable       (enable0),
      .cfg_update   (cfg0),
      .cfg_pending  (pending0),
      .active_mask  (mask0),
      .active_count (count0),
      .slot         (bus0.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] s(input bit ts, input int ch,
                                    input bit first, input bit last);
      return {ts, first, last, ch[1:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a();
      q.push_back(s(1, 0, 1, 0));
      q.push_back(s(0, 0, 0, 0));
      q.push_back(s(0, 1, 0, 0));
      q.push_back(s(0, 3, 0, 1));
   endtask

   // Score any accepted slot, then advance one clock.
   task automatic cyc();
      #1;
      if (bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) chk("sb_underflow", 1, 0);
         else chk("slot", {bus.out_ts, bus.out_first, bus.out_last,
                           bus.out_channel}, q.pop_front());
      end
      if (bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) chk("sb0_underflow", 1, 0);
         else chk("slot0", {bus0.out_ts, bus0.out_first, bus0.out_last,
                            bus0.out_channel}, q0.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 0; run = 0; enable = 0; cfg_update = 0;
      run0 = 0; enable0 = 0; cfg0 = 0;
      bus.out_ready = 1; bus0.out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_first", bus.out_first, 0);
      chk("rst_mask", active_mask, 0);
      chk("rst_count", active_count, 0);
      chk("rst_pending", cfg_pending, 0);
      resetn = 1;

      // single channel, no timestamp
      enable0 = 4'b0001; cfg0 = 1; run0 = 1;
      cyc();
      cfg0 = 0;
      chk("t4_load_valid", bus0.out_valid, 0);
      cyc();
      chk("t4_count", count0, 1);
      repeat (3) q0.push_back(s(0, 0, 1, 1));
      for (int i = 0; i < 2; i++) begin
         chk("t4_valid", bus0.out_valid, 1);
         cyc();
      end
      run0 = 0;
      cyc();
      chk("t4_idle", bus0.out_valid, 0);
      chk("t4_drain", q0.size(), 0);

      // basic frames with timestamp
      enable = 4'b1011; cfg_update = 1;
      cyc();
      cfg_update = 0;
      chk("t1_pending", cfg_pending, 1);
      run = 1;
      cyc();
      chk("t1_load_valid", bus.out_valid, 0);
      cyc();
      chk("t1_count", active_count, 3);
      chk("t1_pending_clr", cfg_pending, 0);
      push_a();
      push_a();
      for (int i = 0; i < 8; i++) begin
         chk("t1_nogap", bus.out_valid, 1);
         cyc();
      end

      // backpressure on ch1
      push_a();
      cyc();
      cyc();
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_hold_valid", bus.out_valid, 1);
         chk("t2_hold_ch", bus.out_channel, 1);
         cyc();
      end
      bus.out_ready = 1;
      cyc();
      cyc();
      chk("t2_drain", q.size(), 0);

      // mid-frame reconfiguration
      push_a();
      repeat (2) begin
         q.push_back(s(1, 0, 1, 0));
         q.push_back(s(0, 2, 0, 1));
      end
      cyc();
      enable = 4'b0100; cfg_update = 1;
      cyc();
      cfg_update = 0;
      chk("t3_pending", cfg_pending, 1);
      cyc();
      cyc();
      chk("t3_bubble", bus.out_valid, 0);
      chk("t3_count_old", active_count, 3);
      cyc();
      chk("t3_count", active_count, 1);
      chk("t3_mask", active_mask, 4'b0100);
      chk("t3_pending_clr", cfg_pending, 0);
      cyc();
      cyc();
      run = 0;
      cyc();
      cyc();
      chk("t3_idle", bus.out_valid, 0);
      chk("t3_drain", q.size(), 0);

      // enable change without cfg_update is ignored
      enable = 4'b1111; run = 1;
      q.push_back(s(1, 0, 1, 0));
      q.push_back(s(0, 2, 0, 1));
      cyc();
      cyc();
      chk("ign_count", active_count, 1);
      chk("ign_mask", active_mask, 4'b0100);
      run = 0;
      cyc();
      cyc();
      chk("ign_idle", bus.out_valid, 0);
      chk("ign_drain", q.size(), 0);

      // empty mask never produces a slot
      enable = 4'b0000; cfg_update = 1; run = 1;
      cyc();
      cfg_update = 0;
      for (int i = 0; i < 6; i++) begin
         chk("t5_valid", bus.out_valid, 0);
         cyc();
      end
      chk("t5_count", active_count, 0);
      chk("t5_mask", active_mask, 0);
      chk("t5_pending", cfg_pending, 0);
      run = 0;
      cyc();
      cyc();

      // asynchronous reset mid-frame
      enable = 4'b1011; cfg_update = 1; run = 1;
      cyc();
      cfg_update = 0;
      cyc();
      chk("t6_count", active_count, 3);
      q.push_back(s(1, 0, 1, 0));
      q.push_back(s(0, 0, 0, 0));
      cyc();
      cyc();
      chk("t6_ch", bus.out_channel, 1);
      chk("t6_valid", bus.out_valid, 1);
      #2;
      resetn = 0;
      #1;
      chk("t6_async_valid", bus.out_valid, 0);
      chk("t6_async_ch", bus.out_channel, 0);
      chk("t6_async_count", active_count, 0);
      chk("t6_async_mask", active_mask, 0);
      @(posedge clk);
      #1;
      resetn = 1;
      cyc();
      chk("t6_reload_valid", bus.out_valid, 0);
      cyc();
      chk("t6_restart_valid", bus.out_valid, 1);
      chk("t6_restart_count", active_count, 3);
      push_a();
      run = 0;
      repeat (4) cyc();
      chk("t6_idle", bus.out_valid, 0);
      chk("t6_drain", q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
